// File: rtl/apb_regfile_completer.sv
// APB completer giving the bridge link a known-good target: ID, control, counters and scratch words.
// Every output is registered. pready is stretched by WAIT_STATES access cycles before the single completion cycle.
module apb_regfile_completer #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_SCRATCH = 4,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'h4c554c5a
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_slverr;
    logic [DATA_WIDTH-1:0] r_ctrl;
    logic [DATA_WIDTH-1:0] r_cycles;
    logic [DATA_WIDTH-1:0] r_xfers;
    logic [DATA_WIDTH-1:0] r_errors;

    logic                  w_setup;
    logic                  w_req_write;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_err;
    logic                  w_hit_ctrl;
    logic                  w_hit_scr;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_commit;
    logic                  w_ok_write;
    logic                  w_ctrl_wr;
    logic                  w_scr_wr;
    logic                  w_clear;
    logic                  w_ready_next;
    logic [DATA_WIDTH-1:0] w_rdata_next;
    logic                  w_slverr_next;
    logic [DATA_WIDTH-1:0] w_scratch [8];

    // In IDLE the response is decoded straight off the bus so zero-wait reads complete in the first access cycle.
    assign w_setup     = (r_state == S_IDLE) && psel && !penable;
    assign w_req_write = (r_state == S_IDLE) ? pwrite : r_write;
    assign w_req_addr  = (r_state == S_IDLE) ? paddr  : r_addr;

    always_comb begin
        w_err      = 1'b0;
        w_hit_ctrl = 1'b0;
        w_hit_scr  = 1'b0;
        w_rd_word  = '0;
        if (w_req_addr[1:0] != 2'b00 || (|w_req_addr[ADDR_WIDTH-1:6])) begin
            w_err = 1'b1;
        end else if (w_req_addr[5]) begin
            if (int'(w_req_addr[4:2]) >= NUM_SCRATCH) begin
                w_err = 1'b1;
            end else begin
                w_hit_scr = 1'b1;
                w_rd_word = w_scratch[w_req_addr[4:2]];
            end
        end else begin
            case (w_req_addr[4:2])
                3'd0:    w_rd_word = ID_VALUE;
                3'd1:    begin w_hit_ctrl = 1'b1; w_rd_word = r_ctrl; end
                3'd2:    w_rd_word = r_cycles;
                3'd3:    w_rd_word = r_xfers;
                3'd4:    w_rd_word = r_errors;
                default: w_err = 1'b1;
            endcase
            if (w_req_write && !w_hit_ctrl) begin
                w_err = 1'b1;
            end
        end
    end

    // Side effects land on the edge that ends the pready cycle.
    assign w_commit   = (r_state == S_DONE);
    assign w_ok_write = w_commit && r_write && !w_err;
    assign w_ctrl_wr  = w_ok_write && w_hit_ctrl;
    assign w_scr_wr   = w_ok_write && w_hit_scr;
    assign w_clear    = w_ctrl_wr && r_wdata[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_setup) w_state_next = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (!psel) begin
                    w_state_next = S_IDLE;
                end else if (penable && r_cnt == 4'd1) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_next  = (w_state_next == S_DONE);
        w_rdata_next  = (w_ready_next && !w_req_write && !w_err) ? w_rd_word : '0;
        w_slverr_next = w_ready_next && w_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_slverr <= 1'b0;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_ready  <= w_ready_next;
            r_rdata  <= w_rdata_next;
            r_slverr <= w_slverr_next;
            if (w_setup) begin
                r_cnt   <= 4'(WAIT_STATES);
                r_write <= pwrite;
                r_addr  <= paddr;
                r_wdata <= pwdata;
            end else if (r_state == S_WAIT && psel && penable && r_cnt != 4'd1) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Clear wins over any increment landing on the same edge; the clearing write is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl   <= DATA_WIDTH'(1);
            r_cycles <= '0;
            r_xfers  <= '0;
            r_errors <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= {r_wdata[DATA_WIDTH-1:2], 1'b0, r_wdata[0]};
            end
            if (w_clear) begin
                r_cycles <= '0;
                r_xfers  <= '0;
                r_errors <= '0;
            end else begin
                if (r_ctrl[0]) r_cycles <= r_cycles + 1'b1;
                if (w_commit)  r_xfers  <= r_xfers + 1'b1;
                if (w_commit && w_err) r_errors <= r_errors + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_scr
            if (gi < NUM_SCRATCH) begin : g_rw
                logic [DATA_WIDTH-1:0] r_word;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_word <= '0;
                    end else if (w_scr_wr && w_req_addr[4:2] == 3'(gi)) begin
                        r_word <= r_wdata;
                    end
                end
                assign w_scratch[gi] = r_word;
            end else begin : g_none
                assign w_scratch[gi] = '0;
            end
        end
    endgenerate

    assign pready  = r_ready;
    assign prdata  = r_rdata;
    assign pslverr = r_slverr;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: a zero-wait and a three-wait instance driven against a register-map model.
// The model tracks register contents per clock edge; the driver schedules when pready must appear.
module tb_apb_regfile_completer;

    localparam logic [31:0] ID = 32'h4c554c5a;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    always #5 clk = ~clk;

    apb_regfile_completer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SCRATCH(4), .WAIT_STATES(0), .ID_VALUE(ID)
    ) u_ws0 (
        .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
    );

    apb_regfile_completer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SCRATCH(4), .WAIT_STATES(3), .ID_VALUE(ID)
    ) u_ws3 (
        .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
    );

    // Register-map model, one copy per instance
    logic [31:0] m_ctrl   [2];
    logic [31:0] m_cycles [2];
    logic [31:0] m_xfers  [2];
    logic [31:0] m_errors [2];
    logic [31:0] m_scr    [2][8];
    bit          pend      [2];
    bit          pend_wr   [2];
    bit          pend_err  [2];
    logic [31:0] pend_addr [2];
    logic [31:0] pend_wdata[2];

    // Expected outputs for the current cycle
    bit          exp_ready [2];
    bit          exp_err   [2];
    logic [31:0] exp_data  [2];
    bit          lit_en    [2];
    logic [31:0] lit_val   [2];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void model_reset(input int d);
        m_ctrl[d]   = 32'h1;
        m_cycles[d] = '0;
        m_xfers[d]  = '0;
        m_errors[d] = '0;
        for (int i = 0; i < 8; i++) m_scr[d][i] = '0;
        pend[d] = 1'b0;
    endfunction

    function automatic void model_decode(input int d, input bit wr, input logic [31:0] a,
                                         output bit err, output logic [31:0] data);
        int idx;
        err  = 1'b0;
        data = '0;
        if (a[1:0] != 2'b00 || a > 32'h3C) begin
            err = 1'b1;
        end else if (a >= 32'h20) begin
            idx = int'((a - 32'h20) >> 2);
            if (idx >= 4) err = 1'b1;
            else if (!wr) data = m_scr[d][idx];
        end else begin
            case (a)
                32'h00:  if (wr) err = 1'b1; else data = ID;
                32'h04:  if (!wr) data = m_ctrl[d];
                32'h08:  if (wr) err = 1'b1; else data = m_cycles[d];
                32'h0C:  if (wr) err = 1'b1; else data = m_xfers[d];
                32'h10:  if (wr) err = 1'b1; else data = m_errors[d];
                default: err = 1'b1;
            endcase
        end
    endfunction

    // Advance the model across one rising edge.
    function automatic void edge_update();
        bit inc;
        bit clr;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                model_reset(d);
            end else begin
                inc = m_ctrl[d][0];
                clr = 1'b0;
                if (pend[d]) begin
                    pend[d] = 1'b0;
                    if (pend_err[d]) begin
                        m_xfers[d]++;
                        m_errors[d]++;
                    end else begin
                        if (pend_wr[d]) begin
                            if (pend_addr[d] == 32'h04) begin
                                m_ctrl[d] = pend_wdata[d] & ~32'h2;
                                clr = pend_wdata[d][1];
                            end else begin
                                m_scr[d][int'((pend_addr[d] - 32'h20) >> 2)] = pend_wdata[d];
                            end
                        end
                        m_xfers[d]++;
                    end
                end
                if (clr) begin
                    m_cycles[d] = '0;
                    m_xfers[d]  = '0;
                    m_errors[d] = '0;
                end else if (inc) begin
                    m_cycles[d]++;
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        edge_update();
        #1;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int abort_at, input bit chk_lit, input logic [31:0] lit);
        int          ws;
        bit          err;
        logic [31:0] data;
        ws   = (d == 1) ? 3 : 0;
        err  = 1'b0;
        data = '0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
        if (ws == 0) model_decode(d, wr, addr, err, data);
        step();
        // Latched values must win over whatever the bus shows during access
        penable[d] = 1'b1;
        paddr[d]   = $urandom;
        pwdata[d]  = $urandom;
        for (int k = 0; k < ws; k++) begin
            if (k == abort_at) begin
                psel[d] = 1'b0; penable[d] = 1'b0;
                $display("[TB] inst%0d %s addr=%h aborted after %0d wait cycles", d, wr ? "WR" : "RD", addr, k);
                step();
                return;
            end
            if (k == ws - 1) model_decode(d, wr, addr, err, data);
            step();
            pwdata[d] = $urandom;
        end
        exp_ready[d] = 1'b1; exp_err[d] = err; exp_data[d] = data;
        lit_en[d] = chk_lit; lit_val[d] = lit;
        pend[d] = 1'b1; pend_wr[d] = wr; pend_err[d] = err; pend_addr[d] = addr; pend_wdata[d] = wdata;
        $display("[TB] inst%0d %s addr=%h wdata=%h expect rdata=%h slverr=%0d", d, wr ? "WR" : "RD",
                 addr, wdata, data, err);
        step();
        exp_ready[d] = 1'b0; lit_en[d] = 1'b0;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    // Start a write to 0x24 and hit reset after k access cycles.
    task automatic reset_during(input int d, input int k);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = 32'h24; pwdata[d] = 32'hCAFE0000 | d;
        step();
        penable[d] = 1'b1;
        for (int i = 0; i < k; i++) step();
        rst = 1'b1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        exp_ready[d] = 1'b0;
        model_reset(0);
        model_reset(1);
        $display("[TB] inst%0d reset asserted after %0d access cycles of write to 0x24", d, k);
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (pready[d] !== exp_ready[d]) begin
                n_fail++;
                $display("FAIL pready inst%0d t=%0t: got %b, want %b", d, $time, pready[d], exp_ready[d]);
            end
            if (exp_ready[d] || rst) begin
                n_tests++;
                if (pslverr[d] !== (exp_ready[d] ? exp_err[d] : 1'b0)) begin
                    n_fail++;
                    $display("FAIL pslverr inst%0d t=%0t: got %b, want %b", d, $time, pslverr[d],
                             exp_ready[d] ? exp_err[d] : 1'b0);
                end
                n_tests++;
                if (prdata[d] !== (exp_ready[d] ? exp_data[d] : 32'h0)) begin
                    n_fail++;
                    $display("FAIL prdata inst%0d t=%0t: got %h, want %h", d, $time, prdata[d],
                             exp_ready[d] ? exp_data[d] : 32'h0);
                end
            end
            if (exp_ready[d] && lit_en[d]) begin
                n_tests++;
                if (prdata[d] !== lit_val[d]) begin
                    n_fail++;
                    $display("FAIL literal inst%0d t=%0t: got %h, want %h", d, $time, prdata[d], lit_val[d]);
                end
            end
        end
    end

    initial begin
        int          d;
        bit          wr;
        int          r;
        int          abort_at;
        logic [31:0] a;
        logic [31:0] w;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
            exp_ready[i] = 1'b0; exp_err[i] = 1'b0; exp_data[i] = '0; lit_en[i] = 1'b0; lit_val[i] = '0;
            model_reset(i);
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // Scratch write then back-to-back readback, then XFERS
        xfer(0, 1'b1, 32'h20, 32'hDEADBEEF, -1, 1'b0, '0);
        xfer(0, 1'b0, 32'h20, 32'h0, -1, 1'b1, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h0C, 32'h0, -1, 1'b1, 32'd2);
        xfer(0, 1'b0, 32'h00, 32'h0, -1, 1'b1, ID);
        xfer(0, 1'b0, 32'h04, 32'h0, -1, 1'b1, 32'h1);
        xfer(1, 1'b0, 32'h00, 32'h0, -1, 1'b1, ID);

        // Wait-state instance: clear, one read, one aborted read, then XFERS
        xfer(1, 1'b1, 32'h04, 32'h3, -1, 1'b0, '0);
        xfer(1, 1'b0, 32'h00, 32'h0, -1, 1'b1, ID);
        xfer(1, 1'b0, 32'h10, 32'h0, 1, 1'b0, '0);
        step();
        xfer(1, 1'b0, 32'h0C, 32'h0, -1, 1'b1, 32'd1);

        // Decode errors leave no trace except in the counters
        xfer(0, 1'b1, 32'h04, 32'h3, -1, 1'b0, '0);
        xfer(0, 1'b1, 32'h08, 32'h11111111, -1, 1'b0, '0);
        xfer(0, 1'b1, 32'h02, 32'h22222222, -1, 1'b0, '0);
        xfer(0, 1'b1, 32'h30, 32'h33333333, -1, 1'b0, '0);
        xfer(0, 1'b0, 32'h10, 32'h0, -1, 1'b1, 32'd3);
        xfer(0, 1'b0, 32'h0C, 32'h0, -1, 1'b1, 32'd4);

        // Cycle counter freeze, then clear with extra CONTROL bits stored
        xfer(0, 1'b1, 32'h04, 32'h0, -1, 1'b0, '0);
        xfer(0, 1'b0, 32'h08, 32'h0, -1, 1'b0, '0);
        step();
        step();
        xfer(0, 1'b0, 32'h08, 32'h0, -1, 1'b0, '0);
        xfer(0, 1'b1, 32'h04, 32'hA5A50003, -1, 1'b0, '0);
        xfer(0, 1'b0, 32'h08, 32'h0, -1, 1'b1, 32'd0);
        xfer(0, 1'b0, 32'h0C, 32'h0, -1, 1'b1, 32'd1);
        xfer(0, 1'b0, 32'h10, 32'h0, -1, 1'b1, 32'd0);
        xfer(0, 1'b0, 32'h04, 32'h0, -1, 1'b1, 32'hA5A50001);

        // Reset in the middle of transfers
        reset_during(1, 1);
        xfer(1, 1'b0, 32'h24, 32'h0, -1, 1'b1, 32'h0);
        xfer(1, 1'b0, 32'h04, 32'h0, -1, 1'b1, 32'h1);
        reset_during(0, 0);
        xfer(0, 1'b0, 32'h24, 32'h0, -1, 1'b1, 32'h0);

        // Randomized traffic over both instances
        for (int n = 0; n < 400; n++) begin
            d  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 15);
            if (r <= 4)       a = 32'(4 * r);
            else if (r <= 12) a = 32'h20 + 32'(4 * (r - 5));
            else if (r == 13) a = 32'(4 * $urandom_range(0, 15)) | 32'($urandom_range(1, 3));
            else if (r == 14) a = 32'h14 + 32'(4 * $urandom_range(0, 2));
            else              a = (32'h40 << $urandom_range(0, 25)) | 32'(4 * $urandom_range(0, 7));
            w = $urandom;
            if (a == 32'h04 && $urandom_range(0, 7) != 0) w[1] = 1'b0;
            abort_at = (d == 1 && $urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
            xfer(d, wr, a, w, abort_at, 1'b0, '0);
            if ($urandom_range(0, 15) == 0) begin
                // Access phase with no setup must be ignored
                psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b1; paddr[d] = 32'h20; pwdata[d] = $urandom;
                step();
                psel[d] = 1'b0; penable[d] = 1'b0;
            end
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_regfile_completer.md
Name: apb_regfile_completer

Overview:
- APB completer (responder) terminating the APB link at the far end of the GTY APB bridge.
- Sits on the Artix-side fabric behind the bridge's requester port. Gives the link a known-good target: ID, control, cycle/transfer/error counters and scratch registers.
- Configurable wait states exercise pready stretching across the bridge.

Parameters:
ADDR_WIDTH, 32, paddr width
DATA_WIDTH, 32, pwdata/prdata width (fixed 32 in this block)
NUM_SCRATCH, 4, number of RW scratch words, legal 1..8
WAIT_STATES, 0, access-phase cycles with pready low before completion, legal 0..15
ID_VALUE, 32'h4c554c5a, constant returned by ID register

Ports:
clk  input  1  single clock (APB pclk)
rst  input  1  reset, asynchronous, active-high
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_WIDTH  byte address
pwdata  input  32  write data
pready  output  1  transfer complete
prdata  output  32  read data, valid only when pready && !pwrite
pslverr  output  1  error response, valid only when pready

Behaviour:
- Reset (async assert, sync release): pready=0, prdata=0, pslverr=0, FSM=IDLE, CONTROL=32'h1, all counters and scratch=0.
- All outputs registered.
- Register map (byte addresses):
  - 0x00 ID: RO, ID_VALUE.
  - 0x04 CONTROL: RW. bit0 = cycle-counter enable. bit1 = counter clear, self-clearing, reads 0. Other bits RW storage.
  - 0x08 CYCLES: RO. Increments every clk while CONTROL[0]=1; wraps at 2^32.
  - 0x0C XFERS: RO. Counts completed transfers (ok and error); wraps.
  - 0x10 ERRORS: RO. Counts transfers completed with pslverr; wraps.
  - 0x20+4*i SCRATCH[i]: RW, for i < NUM_SCRATCH.
- Decode errors (pslverr=1, no side effects):
  - paddr[1:0] != 0;
  - unmapped address (including scratch index >= NUM_SCRATCH and any upper paddr bits set);
  - write to a RO register.
- FSM:
  - IDLE: psel && !penable (setup) latches pwrite/paddr/pwdata and sets wait counter = WAIT_STATES. If WAIT_STATES=0, go to DONE, driving pready=1 in the first access cycle. Otherwise go to WAIT.
  - WAIT: while psel && penable, decrement the counter. When the counter hits 1, go to DONE (pready=1 next cycle). Total pready-low access cycles = WAIT_STATES.
  - DONE: pready=1, pslverr and prdata valid for exactly one cycle. Go to IDLE next edge. prdata=0 for writes and errored reads.
- Write commit: at the clock edge ending the pready cycle; a read of the same register in the next transfer returns the new value.
- XFERS/ERRORS increment at that same edge.
- Clear vs increment: CONTROL[1] write clears CYCLES/XFERS/ERRORS at commit; the clearing transfer itself is not counted. Clear takes priority over a simultaneous increment.
- Back-to-back: a new setup phase in the cycle after pready is accepted with no dead cycle.
- Protocol violations:
  - psel deasserted during WAIT: abort to IDLE with no write and no count.
  - penable without a preceding setup in IDLE: ignored.
  - Latched address/data are used; pwdata changes during access are ignored.
- Reset mid-transfer: immediate return to IDLE with pready=0; the pending write is discarded.

Test Plan:
1. After reset, read 0x00 with WAIT_STATES=0 -> pready high in the first access cycle, prdata=32'h4c554c5a, pslverr=0. Then read 0x04 -> 32'h1.
2. Write 0xDEADBEEF to 0x20, then read 0x20 back-to-back -> prdata=0xDEADBEEF. XFERS read next = 2 (write, read; the XFERS read itself is counted after its completion).
3. WAIT_STATES=3: any read -> exactly 3 access cycles with pready=0, then 1 cycle pready=1. Abort by dropping psel after 1 wait cycle -> no pready, XFERS unchanged.
4. Writes to 0x08, 0x02, 0x30 (NUM_SCRATCH=4) -> pslverr=1 each, no state change. ERRORS reads 3.
5. Write CONTROL=0x0 and sample CYCLES twice -> equal values. Write CONTROL=0x3 -> CYCLES/XFERS/ERRORS cleared. Subsequent CONTROL read = 0x1.
6. Assert rst during WAIT of a write to 0x24 -> pready=0 immediately, 0x24 reads 0 after release, CONTROL=0x1.
